serial_word_shifter: RTL
========================

SERIAL_WORD_SHIFTER -- requirements
Module: serial_word_shifter

Interface
REQ-001 Parameter: W, 8, word width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  upstream word offered.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_data  input  W  word to serialize, MSB sent first.
REQ-007 Port: a  output  1  serial bit stream feeding the sequence detectors.
REQ-008 Port: a_valid  output  1  a carries a payload bit this cycle.

Function
REQ-009 The block SHALL accept a word on a rising edge where in_valid and in_ready are both 1, and only then.
REQ-010 The block SHALL hold one accepted word in a one-entry hold buffer (hold_data, hold_full) until the shifter loads it.
REQ-011 in_ready SHALL equal NOT hold_full, combinationally from registered state only, with no dependence on in_valid.
REQ-012 The block SHALL implement two states: IDLE (a_valid=0) and SHIFT (a_valid=1).
REQ-013 IDLE->SHIFT SHALL occur on an edge where hold_full=1: shift register <= hold_data, bit counter <= 0, hold_full <= 0.
REQ-014 In SHIFT, each edge SHALL shift the register left by one and increment the counter, until the counter reaches W-1.
REQ-015 On the edge where counter = W-1: with hold_full=1, the block SHALL reload and remain in SHIFT with no gap cycle; with hold_full=0, it SHALL go to IDLE.
REQ-016 a SHALL equal the shift register MSB in SHIFT and 0 in IDLE; a and a_valid SHALL be driven from registers with no combinational path from inputs.
REQ-017 Latency: word accepted at edge k -> its MSB on a in the cycle after edge k+1 when IDLE; exactly W consecutive a_valid=1 cycles per word.
REQ-018 Back-to-back words offered continuously SHALL produce an unbroken stream: a_valid stays 1 and every word occupies exactly W cycles.
REQ-019 While in_ready=0, in_data and in_valid SHALL be ignored; a held in_valid SHALL be accepted exactly once, when in_ready returns to 1.
REQ-020 Acceptance into the hold buffer and a load out of it on the same edge is impossible by REQ-011; no word SHALL be lost or duplicated.
REQ-021 The bit counter SHALL be ceil(log2(W)) bits wide and SHALL never exceed W-1.

Reset
REQ-022 On a rising edge with rst=1: state IDLE, hold_full=0, counter=0, shift register=0; therefore a=0, a_valid=0, in_ready=1 in the following cycle.
REQ-023 rst SHALL take priority over acceptance and shifting; a word partially sent or held at reset SHALL be discarded with no remaining bits emitted.
REQ-024 Inputs offered while rst=1 SHALL NOT be accepted.

Verification
REQ-025 Reset: rst=1 for 2 edges with in_valid=1 -> a=0, a_valid=0, in_ready=1 afterwards; nothing emitted.
REQ-026 Single word W=8, in_data=8'b0011_0101 accepted at edge k -> from the cycle after edge k+1, a = 0,0,1,1,0,1,0,1 with a_valid=1 for exactly 8 cycles, then a_valid=0.
REQ-027 Back-to-back 8'h35, 8'h99, 8'h9A with in_valid held high -> 24 contiguous a_valid cycles carrying 0011_0101_1001_1001_1001_1010; in_ready pulses once per word.
REQ-028 Backpressure: in_valid held with 8'hA8 while hold is full -> no accept until in_ready=1; word emitted exactly once.
REQ-029 Reset mid-word: rst asserted after 3 bits of 8'hFF, with 8'h0F held -> a_valid=0 next cycle; neither remainder nor held word emitted.
REQ-030 Idle gap: word 8'h01, 5 idle cycles, word 8'h80 -> a_valid low for 5+1 cycles between words, bits correct in both.

Source files
------------

// File: rtl/serial_word_shifter.sv
// Word-to-bit serializer: a one-entry hold buffer feeds a MSB-first shift register,
// producing a gapless bit stream (a / a_valid) for downstream sequence detectors.
//
//   state | meaning
//   IDLE  | shifter empty, a_valid=0, waiting for the hold buffer to fill
//   SHIFT | emitting shift register MSB each cycle, a_valid=1
module serial_word_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         a,
    output logic         a_valid
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   hold_data;
    logic           hold_full;
    logic [W-1:0]   shreg;
    logic [CW-1:0]  cnt;
    logic           accept;
    logic           load;
    logic           last_bit;

    // accept needs an empty hold buffer and load needs a full one, so they never coincide
    always_comb begin
        accept     = in_valid && !hold_full;
        last_bit   = (state == SHIFT) && (cnt == CNT_LAST);
        load       = hold_full && ((state == IDLE) || last_bit);
        state_next = state;
        if (load) begin
            state_next = SHIFT;
        end else if (last_bit) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
        end else begin
            if (load) begin
                shreg     <= hold_data;
                cnt       <= '0;
                hold_full <= 1'b0;
            end else if (state == SHIFT) begin
                if (last_bit) begin
                    shreg <= '0;
                    cnt   <= '0;
                end else begin
                    shreg <= {shreg[W-2:0], 1'b0};
                    cnt   <= cnt + CW'(1);
                end
            end
            if (accept) begin
                hold_data <= in_data;
                hold_full <= 1'b1;
            end
        end
    end

    assign in_ready = !hold_full;
    assign a_valid  = (state == SHIFT);
    assign a        = (state == SHIFT) && shreg[W-1];

endmodule
